fmul_pipe: RTL and testbench

Pipelined, parametrised IEEE-754-style floating-point multiplier with valid/ready handshakes on input and output. It generalises the single-precision combinational `fmul` to arbitrary exponent and mantissa widths. It adds round-to-nearest-even, special-value handling, exception flags, and a fixed 3-cycle latency at one result per cycle. It sits between operand producers and result consumers in the FP datapath and can apply backpressure.

---
 rtl/fmul_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_fmul_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_pipe.sv
// Pipelined floating-point multiplier: round-to-nearest-even, special values, exception flags.
// Operands are registered on acceptance, then classify, multiply and round/pack stages follow.
module fmul_pipe #(
   parameter int EXP_WIDTH = 8,
   parameter int MAN_WIDTH = 23,
   localparam int DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] c_o,
   output logic [3:0]            flags_o
);

   localparam int EW = EXP_WIDTH;
   localparam int MW = MAN_WIDTH;
   localparam int PW = 2 * MW + 2;
   localparam int XW = EW + 2;

   localparam logic signed [XW-1:0] BIAS     = XW'((2 ** (EW - 1)) - 1);
   localparam logic signed [XW-1:0] EXP_MAX  = XW'((2 ** EW) - 1);
   localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
   localparam logic signed [XW-1:0] EXP_ZERO = '0;
   localparam logic [DATA_WIDTH-1:0] QNAN    = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

   typedef enum logic [1:0] {
      KIND_NORMAL,
      KIND_NAN,
      KIND_INF,
      KIND_ZERO
   } kind_t;

   logic en;

   logic                  s1_valid;
   logic [DATA_WIDTH-1:0] s1_a;
   logic [DATA_WIDTH-1:0] s1_b;

   logic                  s2_valid;
   logic                  s2_sign;
   kind_t                 s2_kind;
   logic                  s2_invalid;
   logic signed [XW-1:0]  s2_exp;
   logic [MW:0]           s2_ma;
   logic [MW:0]           s2_mb;

   logic                  s3_valid;
   logic                  s3_sign;
   kind_t                 s3_kind;
   logic                  s3_invalid;
   logic signed [XW-1:0]  s3_exp;
   logic [PW-1:0]         s3_prod;

   assign en      = !valid_o || ready_i;
   assign ready_o = en && !rst_i;

   logic          a_sign, b_sign;
   logic [EW-1:0] a_exp, b_exp;
   logic [MW-1:0] a_man, b_man;
   logic          a_nan, a_inf, a_zero;
   logic          b_nan, b_inf, b_zero;

   assign {a_sign, a_exp, a_man} = s1_a;
   assign {b_sign, b_exp, b_man} = s1_b;

   assign a_nan  = (&a_exp) && (a_man != '0);
   assign a_inf  = (&a_exp) && (a_man == '0);
   assign a_zero = (a_exp == '0);
   assign b_nan  = (&b_exp) && (b_man != '0);
   assign b_inf  = (&b_exp) && (b_man == '0);
   assign b_zero = (b_exp == '0);

   kind_t                s1_kind;
   logic                 s1_invalid;
   logic signed [XW-1:0] s1_exp_sum;

   // Special-case priority: NaN input, then inf*0, then inf, then zero (subnormals count as zero).
   always_comb begin
      s1_kind    = KIND_NORMAL;
      s1_invalid = 1'b0;
      if (a_nan || b_nan) begin
         s1_kind = KIND_NAN;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         s1_kind    = KIND_NAN;
         s1_invalid = 1'b1;
      end else if (a_inf || b_inf) begin
         s1_kind = KIND_INF;
      end else if (a_zero || b_zero) begin
         s1_kind = KIND_ZERO;
      end
   end

   assign s1_exp_sum = XW'(a_exp) + XW'(b_exp) - BIAS;

   logic [PW-1:0] s2_prod;
   assign s2_prod = PW'(s2_ma) * PW'(s2_mb);

   logic [MW-1:0]        frac_t;
   logic                 guard;
   logic                 sticky;
   logic signed [XW-1:0] exp_n;

   always_comb begin
      frac_t = '0;
      guard  = 1'b0;
      sticky = 1'b0;
      exp_n  = s3_exp;
      if (s3_prod[PW-1]) begin
         frac_t = s3_prod[PW-2 -: MW];
         guard  = s3_prod[MW];
         sticky = |s3_prod[MW-1:0];
         exp_n  = s3_exp + EXP_ONE;
      end else begin
         frac_t = s3_prod[PW-3 -: MW];
         guard  = s3_prod[MW-1];
         sticky = |s3_prod[MW-2:0];
      end
   end

   logic                 round_up;
   logic [MW:0]          frac_r;
   logic signed [XW-1:0] exp_r;
   logic                 inexact;

   // A carry out of the rounded fraction leaves it all-zero, so only the exponent needs bumping.
   assign round_up = guard & (sticky | frac_t[0]);
   assign frac_r   = {1'b0, frac_t} + {{MW{1'b0}}, round_up};
   assign exp_r    = exp_n + (frac_r[MW] ? EXP_ONE : EXP_ZERO);
   assign inexact  = guard | sticky;

   logic [DATA_WIDTH-1:0] res_word;
   logic [3:0]            res_flags;

   always_comb begin
      res_word  = '0;
      res_flags = '0;
      case (s3_kind)
         KIND_NAN: begin
            res_word  = QNAN;
            res_flags = {s3_invalid, 3'b000};
         end
         KIND_INF: begin
            res_word = {s3_sign, {EW{1'b1}}, {MW{1'b0}}};
         end
         KIND_ZERO: begin
            res_word = {s3_sign, {(EW + MW){1'b0}}};
         end
         default: begin
            if (exp_r >= EXP_MAX) begin
               res_word  = {s3_sign, {EW{1'b1}}, {MW{1'b0}}};
               res_flags = 4'b0101;
            end else if (exp_r <= EXP_ZERO) begin
               res_word  = {s3_sign, {(EW + MW){1'b0}}};
               res_flags = 4'b0011;
            end else begin
               res_word  = {s3_sign, exp_r[EW-1:0], frac_r[MW-1:0]};
               res_flags = {3'b000, inexact};
            end
         end
      endcase
   end

   // One global enable: the whole pipe, bubbles included, either shifts or holds.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         valid_o  <= 1'b0;
         c_o      <= '0;
         flags_o  <= '0;
      end else if (en) begin
         s1_valid   <= valid_i;
         s1_a       <= a_i;
         s1_b       <= b_i;

         s2_valid   <= s1_valid;
         s2_sign    <= a_sign ^ b_sign;
         s2_kind    <= s1_kind;
         s2_invalid <= s1_invalid;
         s2_exp     <= s1_exp_sum;
         s2_ma      <= {1'b1, a_man};
         s2_mb      <= {1'b1, b_man};

         s3_valid   <= s2_valid;
         s3_sign    <= s2_sign;
         s3_kind    <= s2_kind;
         s3_invalid <= s2_invalid;
         s3_exp     <= s2_exp;
         s3_prod    <= s2_prod;

         valid_o    <= s3_valid;
         c_o        <= res_word;
         flags_o    <= res_flags;
      end
   end

endmodule

// File: tb/tb_fmul_pipe.sv
// Bench for fmul_pipe: arithmetic reference model with an in-order scoreboard, directed
// vectors, streaming with backpressure, mid-stream reset and a half-precision instance.
module tb_fmul_pipe;

   typedef struct packed {
      logic [63:0] c;
      logic [3:0]  f;
   } model_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [3:0]  f;
   } vec_t;

   localparam int NVEC = 15;

   vec_t vecs [NVEC] = '{
      '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000},
      '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000},
      '{32'hBF800000, 32'h40000000, 32'hC0000000, 4'b0000},
      '{32'h00000000, 32'h40000000, 32'h00000000, 4'b0000},
      '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001},
      '{32'h3F800000, 32'h3F800001, 32'h3F800001, 4'b0000},
      '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000},
      '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000},
      '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000},
      '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101},
      '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011},
      '{32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'b0001},
      '{32'h3FC00000, 32'h3F800003, 32'h3FC00004, 4'b0001},
      '{32'h00400000, 32'h40000000, 32'h00000000, 4'b0000},
      '{32'h80000000, 32'h7F800000, 32'h7FC00000, 4'b1000}
   };

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_i = 1'b0;
   logic        ready_i = 1'b1;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        ready_o;
   logic        valid_o;
   logic [31:0] c_o;
   logic [3:0]  flags_o;

   logic        h_valid_i = 1'b0;
   logic        h_ready_i = 1'b1;
   logic [15:0] h_a = '0;
   logic [15:0] h_b = '0;
   logic        h_ready_o;
   logic        h_valid_o;
   logic [15:0] h_c;
   logic [3:0]  h_flags;

   int checks = 0;
   int errors = 0;
   int received = 0;

   model_t sb [$];

   always #5 clk = ~clk;

   fmul_pipe dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .a_i     (a_i),
      .b_i     (b_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .c_o     (c_o),
      .flags_o (flags_o)
   );

   fmul_pipe #(.EXP_WIDTH(5), .MAN_WIDTH(10)) dut_half (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (h_valid_i),
      .ready_o (h_ready_o),
      .a_i     (h_a),
      .b_i     (h_b),
      .valid_o (h_valid_o),
      .ready_i (h_ready_i),
      .c_o     (h_c),
      .flags_o (h_flags)
   );

   // Exact integer product, then round-to-nearest-even by comparing the remainder with one half.
   function automatic model_t model(input longint a, input longint b, input int ew, input int mw);
      model_t r;
      longint one   = 1;
      longint emask = (one << ew) - 1;
      longint mmask = (one << mw) - 1;
      longint bias  = (one << (ew - 1)) - 1;
      longint ea    = (a >> mw) & emask;
      longint eb    = (b >> mw) & emask;
      longint ma    = a & mmask;
      longint mb    = b & mmask;
      longint sign  = ((a ^ b) >> (ew + mw)) & 1;
      longint qnan  = (emask << mw) | (one << (mw - 1));
      longint inf   = (sign << (ew + mw)) | (emask << mw);
      longint zero  = sign << (ew + mw);
      bit an = (ea == emask) && (ma != 0);
      bit ai = (ea == emask) && (ma == 0);
      bit az = (ea == 0);
      bit bn = (eb == emask) && (mb != 0);
      bit bi = (eb == emask) && (mb == 0);
      bit bz = (eb == 0);
      longint e, p, q, rem, half;
      int sh;
      r.c = '0;
      r.f = 4'b0000;
      if (an || bn) begin
         r.c = qnan;
      end else if ((ai && bz) || (bi && az)) begin
         r.c = qnan;
         r.f = 4'b1000;
      end else if (ai || bi) begin
         r.c = inf;
      end else if (az || bz) begin
         r.c = zero;
      end else begin
         e  = ea + eb - bias;
         p  = ((one << mw) | ma) * ((one << mw) | mb);
         sh = mw;
         if (p >= (one << (2 * mw + 1))) begin
            sh = mw + 1;
            e  = e + 1;
         end
         q    = p >> sh;
         rem  = p & ((one << sh) - 1);
         half = one << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         if (q == (one << (mw + 1))) begin
            q = q >> 1;
            e = e + 1;
         end
         if (e >= emask) begin
            r.c = inf;
            r.f = 4'b0101;
         end else if (e <= 0) begin
            r.c = zero;
            r.f = 4'b0011;
         end else begin
            r.c = (sign << (ew + mw)) | (e << mw) | (q & mmask);
            r.f = {3'b000, rem != 0};
         end
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Call at posedge+1; holds the operands until the pipe takes them.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
      logic taken;
      int   tries;
      a_i     = a;
      b_i     = b;
      valid_i = 1'b1;
      taken   = 1'b0;
      tries   = 0;
      while (!taken && tries < 50) begin
         @(negedge clk);
         taken = ready_o;
         @(posedge clk);
         #1;
         tries++;
      end
      valid_i = 1'b0;
      if (!taken) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: ready_o stayed 0 for %h * %h, required 1", a, b);
      end
   endtask

   task automatic waitResult(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!valid_o && lat < 20);
   endtask

   task automatic runHalf(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [3:0] f);
      model_t m;
      int     lat;
      m = model(64'(a), 64'(b), 5, 10);
      checkOutput("half_model_c", m.c, 64'(c));
      checkOutput("half_model_flags", 64'(m.f), 64'(f));
      h_a       = a;
      h_b       = b;
      h_valid_i = 1'b1;
      @(negedge clk);
      checkOutput("half_ready_o", 64'(h_ready_o), 64'd1);
      @(posedge clk);
      #1;
      h_valid_i = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!h_valid_o && lat < 20);
      checkOutput("half_latency", 64'(lat), 64'd3);
      checkOutput("half_c", 64'(h_c), 64'(c));
      checkOutput("half_flags", 64'(h_flags), 64'(f));
   endtask

   // Scoreboard: expectations enter on input transfer, leave on output transfer, vanish on reset.
   always @(negedge clk) begin
      model_t r;
      if (rst) begin
         sb.delete();
      end else begin
         if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_result: got c_o=%h with no operand outstanding", c_o);
            end else begin
               r = sb.pop_front();
               checkOutput("stream_c", 64'(c_o), r.c);
               checkOutput("stream_flags", 64'(flags_o), 64'(r.f));
               received++;
            end
         end
         if (valid_i && ready_o) sb.push_back(model(64'(a_i), 64'(b_i), 8, 23));
      end
   end

   initial begin
      model_t m;
      int     lat;
      int     base;
      int     t;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_valid_o", 64'(valid_o), 64'd0);
      checkOutput("reset_c_o", 64'(c_o), 64'd0);
      checkOutput("reset_flags_o", 64'(flags_o), 64'd0);
      checkOutput("reset_ready_o", 64'(ready_o), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("first_ready_o", 64'(ready_o), 64'd1);
      @(posedge clk);
      #1;

      for (int i = 0; i < NVEC; i++) begin
         m = model(64'(vecs[i].a), 64'(vecs[i].b), 8, 23);
         checkOutput($sformatf("model_c[%0d]", i), m.c, 64'(vecs[i].c));
         checkOutput($sformatf("model_flags[%0d]", i), 64'(m.f), 64'(vecs[i].f));
         applyStimulus(vecs[i].a, vecs[i].b);
         waitResult(lat);
         checkOutput($sformatf("latency[%0d]", i), 64'(lat), 64'd3);
         checkOutput($sformatf("direct_c[%0d]", i), 64'(c_o), 64'(vecs[i].c));
         checkOutput($sformatf("direct_flags[%0d]", i), 64'(flags_o), 64'(vecs[i].f));
      end

      base = received;
      fork
         begin
            for (int i = 0; i < 8; i++) applyStimulus(vecs[i + 4].a, vecs[i + 4].b);
         end
         begin
            logic [31:0] held_c;
            logic [3:0]  held_f;
            int          w;
            w = 0;
            while (received < base + 2 && w < 100) begin
               @(negedge clk);
               #1;
               w++;
            end
            @(posedge clk);
            #1;
            ready_i = 1'b0;
            held_c  = c_o;
            held_f  = flags_o;
            repeat (4) begin
               @(negedge clk);
               checkOutput("stall_valid_o", 64'(valid_o), 64'd1);
               checkOutput("stall_ready_o", 64'(ready_o), 64'd0);
               checkOutput("stall_c_o", 64'(c_o), 64'(held_c));
               checkOutput("stall_flags_o", 64'(flags_o), 64'(held_f));
            end
            @(posedge clk);
            #1;
            ready_i = 1'b1;
         end
      join
      t = 0;
      while ((received - base) < 8 && t < 60) begin
         @(negedge clk);
         #1;
         t++;
      end
      checkOutput("stream_count", 64'(received - base), 64'd8);
      @(posedge clk);
      #1;

      for (int i = 0; i < 3; i++) applyStimulus(vecs[i + 1].a, vecs[i + 1].b);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_ready_o", 64'(ready_o), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("midrst_valid_o", 64'(valid_o), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postrst_ready_o", 64'(ready_o), 64'd1);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("postrst_idle_valid_o", 64'(valid_o), 64'd0);
      applyStimulus(vecs[1].a, vecs[1].b);
      waitResult(lat);
      checkOutput("postrst_latency", 64'(lat), 64'd3);
      checkOutput("postrst_c", 64'(c_o), 64'(vecs[1].c));
      checkOutput("postrst_flags", 64'(flags_o), 64'(vecs[1].f));
      @(posedge clk);
      #1;

      runHalf(16'h3C00, 16'h4000, 16'h4000, 4'b0000);
      runHalf(16'h7BFF, 16'h4000, 16'h7C00, 4'b0101);
      runHalf(16'h3C01, 16'h3C01, 16'h3C02, 4'b0001);
      runHalf(16'h0400, 16'h3800, 16'h0000, 4'b0011);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
